// File: rtl/lr_sc_reservation_table.sv
// Per-hart LR/SC reservation table: granule tags, forward-progress timeout, cross-hart store snoop.
// SC result is registered and appears one cycle after the SC request; there is no backpressure.
module lr_sc_reservation_table #(
  parameter int XLEN         = 32,
  parameter int NUM_HARTS    = 2,
  parameter int GRANULE_BITS = 2,
  parameter int TIMEOUT      = 64,
  localparam int HID_W       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
  localparam int TW          = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_is_sc,
  input  logic [HID_W-1:0]     req_hart,
  input  logic [XLEN-1:0]      req_addr,
  input  logic                 st_valid,
  input  logic [HID_W-1:0]     st_hart,
  input  logic [XLEN-1:0]      st_addr,
  input  logic [NUM_HARTS-1:0] flush,
  output logic                 resp_valid,
  output logic [HID_W-1:0]     resp_hart,
  output logic                 resp_sc_success,
  output logic [NUM_HARTS-1:0] resv_valid
);

  localparam int TAG_W = XLEN - GRANULE_BITS;

  logic [NUM_HARTS-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q   [NUM_HARTS];
  logic [TW-1:0]        timer_q [NUM_HARTS];

  logic [TAG_W-1:0]     req_tag;
  logic [TAG_W-1:0]     st_tag;
  logic                 req_ok;
  logic                 st_ok;
  logic                 sc_fire;
  logic                 sc_succ;
  logic [NUM_HARTS-1:0] st_kill;
  logic [NUM_HARTS-1:0] sc_kill;
  logic [NUM_HARTS-1:0] req_match;
  logic                 unused_addr_bits;

  assign req_tag          = req_addr[XLEN-1:GRANULE_BITS];
  assign st_tag           = st_addr[XLEN-1:GRANULE_BITS];
  assign unused_addr_bits = ^{req_addr[GRANULE_BITS-1:0], st_addr[GRANULE_BITS-1:0]};
  assign req_ok           = req_valid && (32'(req_hart) < NUM_HARTS);
  assign st_ok            = st_valid && (32'(st_hart) < NUM_HARTS);
  assign sc_fire          = req_ok && req_is_sc;

  always_comb begin
    sc_succ   = 1'b0;
    st_kill   = '0;
    sc_kill   = '0;
    req_match = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      req_match[h] = valid_q[h] && (tag_q[h] == req_tag);
      st_kill[h]   = st_ok && (st_hart != HID_W'(h)) && valid_q[h] && (tag_q[h] == st_tag);
      // Snoop is ordered ahead of the SC, so a same-cycle foreign store wins.
      if (sc_fire && (req_hart == HID_W'(h)))
        sc_succ = req_match[h] && ((TIMEOUT == 0) || (timer_q[h] != '0)) && !flush[h] && !st_kill[h];
    end
    for (int h = 0; h < NUM_HARTS; h++)
      sc_kill[h] = sc_succ && (req_hart != HID_W'(h)) && req_match[h];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        tag_q[h]   <= '0;
        timer_q[h] <= '0;
      end
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (flush[h]) begin
          valid_q[h] <= 1'b0;
        end else if (req_ok && (req_hart == HID_W'(h))) begin
          valid_q[h] <= !req_is_sc;
          if (!req_is_sc) begin
            tag_q[h]   <= req_tag;
            timer_q[h] <= TW'(TIMEOUT);
          end
        end else if (st_kill[h] || sc_kill[h]) begin
          valid_q[h] <= 1'b0;
        end else if (valid_q[h] && (TIMEOUT != 0)) begin
          timer_q[h] <= timer_q[h] - 1'b1;
          if (timer_q[h] == TW'(1))
            valid_q[h] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid      <= 1'b0;
      resp_hart       <= '0;
      resp_sc_success <= 1'b0;
    end else begin
      resp_valid      <= sc_fire;
      resp_sc_success <= sc_succ;
      if (sc_fire)
        resp_hart <= req_hart;
    end
  end

  assign resv_valid = valid_q;

endmodule

// File: tb/tb_lr_sc_reservation_table.sv
// Two table configurations driven in lockstep and checked every cycle against an
// abstract model that tracks each reservation by the cycle of its LR.
module tb_lr_sc_reservation_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_is_sc;
  logic [1:0]  req_hart;
  logic [31:0] req_addr;
  logic        st_valid;
  logic [1:0]  st_hart;
  logic [31:0] st_addr;
  logic [2:0]  flush;

  logic       rv0, rs0, rh0;
  logic [1:0] resv0;
  logic       rv1, rs1;
  logic [1:0] rh1;
  logic [2:0] resv1;

  always #5 clk = ~clk;

  lr_sc_reservation_table #(.XLEN(32), .NUM_HARTS(2), .GRANULE_BITS(2), .TIMEOUT(4)) u0 (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_is_sc(req_is_sc),
    .req_hart(req_hart[0]), .req_addr(req_addr), .st_valid(st_valid),
    .st_hart(st_hart[0]), .st_addr(st_addr), .flush(flush[1:0]),
    .resp_valid(rv0), .resp_hart(rh0), .resp_sc_success(rs0), .resv_valid(resv0));

  lr_sc_reservation_table #(.XLEN(32), .NUM_HARTS(3), .GRANULE_BITS(6), .TIMEOUT(0)) u1 (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_is_sc(req_is_sc),
    .req_hart(req_hart), .req_addr(req_addr), .st_valid(st_valid),
    .st_hart(st_hart), .st_addr(st_addr), .flush(flush),
    .resp_valid(rv1), .resp_hart(rh1), .resp_sc_success(rs1), .resv_valid(resv1));

  int nh_p [2] = '{2, 3};
  int gb_p [2] = '{2, 6};
  int to_p [2] = '{4, 0};

  // Model state: a reservation is live at cycle t if set and t - lr_cycle <= timeout.
  bit          mv   [2][3];
  logic [31:0] mtag [2][3];
  int          mc   [2][3];

  bit       exp_rv [2];
  int       exp_rh [2];
  bit       exp_rs [2];
  bit [2:0] exp_resv [2];

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  bit  chk_en = 0;

  function automatic bit is_live(int i, int h, int t);
    return mv[i][h] && (to_p[i] == 0 || (t - mc[i][h]) <= to_p[i]);
  endfunction

  task automatic model_step(input int i);
    int  nh, gb, rh, sh;
    bit  live [3];
    bit  stk [3];
    bit  rq_ok, st_ok, succ;
    logic [31:0] rtag, stag;
    nh = nh_p[i];
    gb = gb_p[i];
    rh = (i == 0) ? int'(req_hart[0]) : int'(req_hart);
    sh = (i == 0) ? int'(st_hart[0]) : int'(st_hart);
    rtag = req_addr >> gb;
    stag = st_addr >> gb;
    if (rst) begin
      for (int h = 0; h < 3; h++) mv[i][h] = 0;
      exp_rv[i] = 0; exp_rh[i] = 0; exp_rs[i] = 0; exp_resv[i] = '0;
      return;
    end
    rq_ok = req_valid && rh < nh;
    st_ok = st_valid && sh < nh;
    for (int h = 0; h < 3; h++) begin
      live[h] = (h < nh) && is_live(i, h, cyc);
      stk[h]  = st_ok && sh != h && live[h] && mtag[i][h] == stag;
    end
    succ = rq_ok && req_is_sc && live[rh] && mtag[i][rh] == rtag && !flush[rh] && !stk[rh];
    for (int h = 0; h < nh; h++) begin
      if (flush[h]) mv[i][h] = 0;
      else if (rq_ok && rh == h) begin
        if (req_is_sc) mv[i][h] = 0;
        else begin mv[i][h] = 1; mtag[i][h] = rtag; mc[i][h] = cyc; end
      end else if (stk[h] || (succ && live[h] && mtag[i][h] == rtag)) mv[i][h] = 0;
      else mv[i][h] = live[h];
    end
    exp_rv[i] = rq_ok && req_is_sc;
    if (exp_rv[i]) exp_rh[i] = rh;
    exp_rs[i] = succ;
    exp_resv[i] = '0;
    for (int h = 0; h < nh; h++) exp_resv[i][h] = is_live(i, h, cyc + 1);
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("u0.resp_valid", int'(rv0), int'(exp_rv[0]));
      check("u0.resv_valid", int'(resv0), int'(exp_resv[0][1:0]));
      if (exp_rv[0]) begin
        check("u0.resp_hart", int'(rh0), exp_rh[0]);
        check("u0.resp_sc_success", int'(rs0), int'(exp_rs[0]));
      end
      check("u1.resp_valid", int'(rv1), int'(exp_rv[1]));
      check("u1.resv_valid", int'(resv1), int'(exp_resv[1]));
      if (exp_rv[1]) begin
        check("u1.resp_hart", int'(rh1), exp_rh[1]);
        check("u1.resp_sc_success", int'(rs1), int'(exp_rs[1]));
      end
    end
  end

  task automatic drive(input bit r, input bit v, input bit sc, input int h, input int a,
                       input bit sv, input int sh, input int sa, input int fl);
    @(negedge clk);
    rst = r; req_valid = v; req_is_sc = sc; req_hart = 2'(h); req_addr = 32'(a);
    st_valid = sv; st_hart = 2'(sh); st_addr = 32'(sa); flush = 3'(fl);
    model_step(0);
    model_step(1);
    cyc++;
    chk_en = 1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic lr(input int h, input int a);
    drive(0, 1, 0, h, a, 0, 0, 0, 0);
  endtask
  task automatic sc(input int h, input int a);
    drive(0, 1, 1, h, a, 0, 0, 0, 0);
  endtask

  int addrs [4] = '{32'h1000, 32'h1004, 32'h1040, 32'h2000};

  initial begin
    rst = 1; req_valid = 0; req_is_sc = 0; req_hart = 0; req_addr = 0;
    st_valid = 0; st_hart = 0; st_addr = 0; flush = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("pin.reset_resv", int'(exp_resv[0]), 0);

    lr(0, 32'h1000); sc(0, 32'h1003);
    check("pin.t1_success", int'(exp_rs[0]), 1);
    check("pin.t1_resv", int'(exp_resv[0]), 0);

    lr(0, 32'h1000); drive(0, 0, 0, 0, 0, 1, 1, 32'h1002, 0); sc(0, 32'h1000);
    check("pin.t2_foreign_store", int'(exp_rs[0]), 0);
    lr(0, 32'h1000); drive(0, 0, 0, 0, 0, 1, 0, 32'h1002, 0); sc(0, 32'h1000);
    check("pin.t2_own_store", int'(exp_rs[0]), 1);

    lr(1, 32'h40); idle(4); sc(1, 32'h40);
    check("pin.t3_expired", int'(exp_rs[0]), 0);
    check("pin.t3_no_timeout", int'(exp_rs[1]), 1);
    lr(1, 32'h40); idle(3); sc(1, 32'h40);
    check("pin.t3_live", int'(exp_rs[0]), 1);

    lr(0, 32'h80); lr(1, 32'h80); sc(0, 32'h80);
    check("pin.t4_sc0", int'(exp_rs[0]), 1);
    check("pin.t4_resv", int'(exp_resv[0]), 0);
    sc(1, 32'h80);
    check("pin.t4_sc1", int'(exp_rs[0]), 0);

    lr(0, 32'h1000); drive(0, 1, 1, 0, 32'h1000, 0, 0, 0, 1);
    check("pin.t5_flush", int'(exp_rs[0]), 0);
    lr(0, 32'h1000); drive(0, 1, 1, 0, 32'h1000, 1, 1, 32'h1000, 0);
    check("pin.t5_snoop", int'(exp_rs[0]), 0);
    lr(0, 32'h1000); sc(0, 32'h1004);
    check("pin.t5_gran2", int'(exp_rs[0]), 0);
    check("pin.t5_gran6", int'(exp_rs[1]), 1);

    lr(0, 32'h1000); drive(1, 1, 1, 0, 32'h1000, 0, 0, 0, 0);
    check("pin.t6_resv", int'(exp_resv[0]), 0);
    check("pin.t6_resp", int'(exp_rv[0]), 0);
    sc(0, 32'h1000);
    check("pin.t6_sc", int'(exp_rs[0]), 0);

    lr(3, 32'h1000); lr(0, 32'h1000); drive(0, 0, 0, 0, 0, 1, 3, 32'h1000, 0); sc(0, 32'h1000);
    check("pin.bad_hart", int'(exp_rs[1]), 1);

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 3)), addrs[$urandom_range(0, 3)] + int'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
            addrs[$urandom_range(0, 3)] + int'($urandom_range(0, 3)),
            ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 7)) : 0);
    end
    idle(2);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
